// File: rtl/count_event_generator.sv
// Button/switch front end: synchronises and debounces a push button and emits
// one-cycle count-step pulses (with optional auto-repeat) carrying the switch direction.
module count_event_generator #(
    parameter int unsigned DEBOUNCE_CYCLES      = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 10_000_000,
    parameter bit          REPEAT_EN            = 1'b1
) (
    input  logic clk,
    input  logic resetN,
    input  logic pushButton,
    input  logic slideSwitch,
    output logic countStep,
    output logic countUp,
    output logic buttonState
);

    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TMR_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES)
                                      ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_DELAY,
        HOLD_REPEAT
    } state_t;

    logic [1:0]       pb_ff;
    logic [1:0]       sw_ff;
    logic             pb_sync;
    logic             sw_sync;
    logic [DB_W-1:0]  db_cnt;
    logic [DB_W-1:0]  db_cnt_next;
    logic             button_next;
    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_next;
    logic             step_next;

    assign pb_sync = pb_ff[1];
    assign sw_sync = sw_ff[1];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pb_ff <= '0;
            sw_ff <= '0;
        end else begin
            pb_ff <= {pb_ff[0], pushButton};
            sw_ff <= {sw_ff[0], slideSwitch};
        end
    end

    always_comb begin
        db_cnt_next = '0;
        button_next = buttonState;
        if (pb_sync != buttonState) begin
            if (db_cnt == DB_LAST) begin
                button_next = pb_sync;
            end else begin
                db_cnt_next = db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            db_cnt      <= '0;
            buttonState <= 1'b0;
        end else begin
            db_cnt      <= db_cnt_next;
            buttonState <= button_next;
        end
    end

    // Release is judged on the debouncer's next level so that a release landing
    // on the same edge as a timer expiry suppresses that step.
    always_comb begin
        state_next = state;
        timer_next = timer;
        step_next  = 1'b0;
        case (state)
            IDLE: begin
                // IDLE is only ever entered with buttonState low, so high here is a rising edge
                if (buttonState) begin
                    step_next  = 1'b1;
                    timer_next = '0;
                    state_next = HOLD_DELAY;
                end
            end
            HOLD_DELAY: begin
                if (!button_next) begin
                    state_next = IDLE;
                end else if (REPEAT_EN && (timer == DELAY_LAST)) begin
                    step_next  = 1'b1;
                    timer_next = '0;
                    state_next = HOLD_REPEAT;
                end else if (timer != '1) begin
                    timer_next = timer + 1'b1;
                end
            end
            HOLD_REPEAT: begin
                if (!button_next) begin
                    state_next = IDLE;
                end else if (timer == PERIOD_LAST) begin
                    step_next  = 1'b1;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            timer     <= '0;
            countStep <= 1'b0;
            countUp   <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            countStep <= step_next;
            if (step_next) begin
                countUp <= sw_sync;
            end
        end
    end

endmodule

// File: tb/tb_count_event_generator.sv
// Bench for count_event_generator: directed scenarios plus random button/switch
// activity checked every cycle against a window/schedule reference model.
module tb_count_event_generator;

    localparam int DEB  = 4;
    localparam int DLY  = 20;
    localparam int PER  = 8;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic push_button = 1'b0;
    logic slide_switch = 1'b0;
    logic step_a, up_a, btn_a;
    logic step_b, up_b, btn_b;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: index = clock edge since reset release (0 = release point)
    bit raw_pb [MAXC];
    bit raw_sw [MAXC];
    bit bs_m   [MAXC];
    int e;
    int last_chg;
    int rise;
    bit cu_a, cu_b;

    always #5 clk = ~clk;

    count_event_generator #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY_CYCLES(DLY),
        .REPEAT_PERIOD_CYCLES(PER),
        .REPEAT_EN(1'b1)
    ) dut (
        .clk(clk),
        .resetN(reset_n),
        .pushButton(push_button),
        .slideSwitch(slide_switch),
        .countStep(step_a),
        .countUp(up_a),
        .buttonState(btn_a)
    );

    count_event_generator #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY_CYCLES(DLY),
        .REPEAT_PERIOD_CYCLES(PER),
        .REPEAT_EN(1'b0)
    ) dut_norep (
        .clk(clk),
        .resetN(reset_n),
        .pushButton(push_button),
        .slideSwitch(slide_switch),
        .countStep(step_b),
        .countUp(up_b),
        .buttonState(btn_b)
    );

    task automatic check_eq(input string tag, input logic obs, input logic exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s at t=%0t edge %0d: got %b expected %b", tag, $time, e, obs, exp_v);
        end
    endtask

    function automatic bit pbs(input int k);
        return (k >= 2) ? raw_pb[k-2] : 1'b0;
    endfunction

    function automatic bit sws(input int k);
        return (k >= 2) ? raw_sw[k-2] : 1'b0;
    endfunction

    task automatic start_epoch();
        reset_n  = 1'b1;
        e        = 0;
        bs_m[0]  = 1'b0;
        last_chg = 0;
        rise     = 0;
        cu_a     = 1'b0;
        cu_b     = 1'b0;
    endtask

    // Debounced level flips once the last DEB synced samples all disagree with it;
    // steps follow the rise at +1, then +DLY, then every +PER while still held.
    task automatic model_and_check();
        bit cur, nxt, all_diff, exp_a, exp_b;
        int d;
        cur = bs_m[e-1];
        nxt = cur;
        if (e - DEB >= last_chg) begin
            all_diff = 1'b1;
            for (int k = e - DEB; k < e; k++)
                if (pbs(k) == cur) all_diff = 1'b0;
            if (all_diff) nxt = ~cur;
        end
        if (nxt != cur) last_chg = e;
        if (!cur && nxt) rise = e;
        bs_m[e] = nxt;
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (cur && nxt) begin
            d = e - rise - 1;
            exp_a = (d == 0) || (d >= DLY && ((d - DLY) % PER) == 0);
            exp_b = (d == 0);
        end
        if (exp_a) cu_a = sws(e-1);
        if (exp_b) cu_b = sws(e-1);
        check_eq("step_rep",    step_a, exp_a);
        check_eq("up_rep",      up_a,   cu_a);
        check_eq("btn_rep",     btn_a,  nxt);
        check_eq("step_norep",  step_b, exp_b);
        check_eq("up_norep",    up_b,   cu_b);
        check_eq("btn_norep",   btn_b,  nxt);
    endtask

    task automatic tick(input bit pb, input bit sw);
        if (e >= MAXC - 1) begin
            $display("FAIL model_overflow at t=%0t: edge %0d limit %0d", $time, e, MAXC);
            $fatal(1, "model array exhausted");
        end
        raw_pb[e]    = pb;
        raw_sw[e]    = sw;
        push_button  = pb;
        slide_switch = sw;
        @(posedge clk);
        #1;
        e++;
        model_and_check();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_step_rep"},   step_a, 1'b0);
        check_eq({tag, "_up_rep"},     up_a,   1'b0);
        check_eq({tag, "_btn_rep"},    btn_a,  1'b0);
        check_eq({tag, "_step_norep"}, step_b, 1'b0);
        check_eq({tag, "_up_norep"},   up_b,   1'b0);
        check_eq({tag, "_btn_norep"},  btn_b,  1'b0);
    endtask

    initial begin
        int rem;
        bit lvl, sw;
        int up_seen;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        start_epoch();

        // clean press, switch up
        repeat (10) tick(1'b1, 1'b1);
        repeat (20) tick(1'b0, 1'b1);

        // bounce then settle high with switch down
        for (int i = 0; i < 12; i++) tick(((i / 2) % 2) == 0, 1'b0);
        repeat (15) tick(1'b1, 1'b0);
        repeat (12) tick(1'b0, 1'b0);

        // short glitch
        repeat (3) tick(1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b0);

        // long hold with repeats
        repeat (60) tick(1'b1, 1'b0);
        repeat (20) tick(1'b0, 1'b0);

        // direction change mid-hold
        repeat (30) tick(1'b1, 1'b0);
        repeat (30) tick(1'b1, 1'b1);
        repeat (20) tick(1'b0, 1'b1);

        // release coincident with repeat expiry, then re-press
        repeat (29) tick(1'b1, 1'b0);
        repeat (20) tick(1'b0, 1'b0);
        repeat (10) tick(1'b1, 1'b0);
        repeat (15) tick(1'b0, 1'b0);

        // reset mid-hold with countUp high, button held through release
        repeat (30) tick(1'b1, 1'b1);
        up_seen = int'(up_a);
        check_eq("pre_reset_up", up_a, 1'b1);
        #4;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (10) @(posedge clk);
        #1;
        check_all_zero("held_reset");
        start_epoch();
        repeat (40) tick(1'b1, 1'b1);
        repeat (15) tick(1'b0, 1'b1);

        // random button/switch activity
        rem = 0;
        lvl = 1'b0;
        sw  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rem == 0) begin
                lvl = ~lvl;
                case ($urandom_range(0, 3))
                    0:       rem = $urandom_range(1, 3);
                    1:       rem = $urandom_range(4, 12);
                    2:       rem = $urandom_range(13, 70);
                    default: rem = $urandom_range(1, 2);
                endcase
            end
            if ($urandom_range(0, 15) == 0) sw = ~sw;
            tick(lvl, sw);
            rem--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        if (up_seen < 0) $display("unreachable");
        $finish;
    end

endmodule
